// File: rtl/byte_ram_pkg.sv
// rtl/byte_ram_pkg.sv - shared defaults, state encodings and helpers for byte_ram
package byte_ram_pkg;

  localparam int DW_DEF      = 32;
  localparam int AW_DEF      = 32;
  localparam int MEM_NUM_DEF = 4096;

  // Level of rstn that holds the block in reset
  localparam logic RstnEnable = 1'b0;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Number of byte-offset address bits inside one data word
  function automatic int offset_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/byte_ram_if.sv
// rtl/byte_ram_if.sv - write/read request bus of byte_ram
interface byte_ram_if
  import byte_ram_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic              wen;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic [DW/8-1:0]   w_strb;
  logic              ren;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_data;
  logic              r_valid;
  logic              r_err;
  logic              w_err;
  logic              busy;

  modport master (
    output wen, w_addr, w_data, w_strb, ren, r_addr,
    input  r_data, r_valid, r_err, w_err, busy
  );

  modport slave (
    input  wen, w_addr, w_data, w_strb, ren, r_addr,
    output r_data, r_valid, r_err, w_err, busy
  );

endinterface

// File: rtl/byte_ram_array.sv
// rtl/byte_ram_array.sv - storage array with per-byte write enables and synchronous read
module byte_ram_array
  import byte_ram_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = MEM_NUM_DEF,
  localparam int IW    = $clog2(DEPTH),
  localparam int NB    = DW / 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] w_idx,
  input  logic [DW-1:0] w_data,
  input  logic [NB-1:0] w_strb,
  input  logic          re,
  input  logic [IW-1:0] r_idx,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  // Byte-masked write and read of the pre-write word; storage is never reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
    if (re) q <= mem[r_idx];
  end

endmodule

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - byte-strobed dual-port RAM top; BYTE_RAM_CLEAR_EN enables the reset-time clear sweep
module byte_ram
  import byte_ram_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int MEM_NUM = MEM_NUM_DEF
) (
  input logic      clk,
  input logic      rstn,
  byte_ram_if.slave bus
);

  localparam int NB  = DW / 8;
  localparam int OFS = offset_bits(DW);
  localparam int IW  = $clog2(MEM_NUM);

  state_t          state;
  logic            busy;
  logic            sweep_we;
  logic [IW-1:0]   sweep_idx;

  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   r_idx;
  logic            w_aligned;
  logic            r_aligned;
  logic            accept_w;
  logic            accept_r;
  logic            do_write;
  logic            do_read;
  logic            same_word;
  logic [DW-1:0]   strb_mask;

  logic            arr_we;
  logic [IW-1:0]   arr_widx;
  logic [DW-1:0]   arr_wdata;
  logic [NB-1:0]   arr_strb;
  logic [DW-1:0]   arr_q;

  logic            r_valid_q;
  logic            r_err_q;
  logic            w_err_q;
  logic [DW-1:0]   fwd_mask_q;
  logic [DW-1:0]   fwd_data_q;
  logic [DW-1:0]   r_hold;
  logic [DW-1:0]   r_data_now;
  logic            unused_addr;

`ifdef BYTE_RAM_CLEAR_EN
  state_t          state_next;
  logic [IW-1:0]   sweep_cnt;

  // State and sweep counter; the sweep restarts from word 0 on every reset
  always_ff @(posedge clk or negedge rstn) begin
    if (rstn == RstnEnable) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Leave INIT once the last word has been cleared; READY holds until reset
  always_comb begin
    state_next = state;
    if (state == ST_INIT && sweep_cnt == IW'(MEM_NUM - 1)) state_next = ST_READY;
  end

  assign sweep_idx = sweep_cnt;
`else
  assign state     = ST_READY;
  assign sweep_idx = '0;
`endif

  assign busy     = (state == ST_INIT);
  assign sweep_we = busy;

  assign w_idx     = bus.w_addr[OFS+IW-1:OFS];
  assign r_idx     = bus.r_addr[OFS+IW-1:OFS];
  assign w_aligned = (bus.w_addr[OFS-1:0] == '0);
  assign r_aligned = (bus.r_addr[OFS-1:0] == '0);
  assign accept_w  = bus.wen & ~busy;
  assign accept_r  = bus.ren & ~busy;
  assign do_write  = accept_w & w_aligned;
  assign do_read   = accept_r & r_aligned;
  assign same_word = do_write & do_read & (w_idx == r_idx);

  // Upper address bits only select aliases of the same word
  assign unused_addr = ^{bus.w_addr[AW-1:OFS+IW], bus.r_addr[AW-1:OFS+IW]};

  // Expand byte strobes into a bit mask for write-first forwarding
  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < NB; b++) strb_mask[8*b +: 8] = {8{bus.w_strb[b]}};
  end

  // The clear sweep owns the write port while busy
  assign arr_we    = do_write | sweep_we;
  assign arr_widx  = sweep_we ? sweep_idx : w_idx;
  assign arr_wdata = sweep_we ? '0 : bus.w_data;
  assign arr_strb  = sweep_we ? '1 : bus.w_strb;

  byte_ram_array #(
    .DW    (DW),
    .DEPTH (MEM_NUM)
  ) u_array (
    .clk    (clk),
    .we     (arr_we),
    .w_idx  (arr_widx),
    .w_data (arr_wdata),
    .w_strb (arr_strb),
    .re     (do_read),
    .r_idx  (r_idx),
    .q      (arr_q)
  );

  // Response flags, forwarding capture and held read data
  always_ff @(posedge clk or negedge rstn) begin
    if (rstn == RstnEnable) begin
      r_valid_q  <= 1'b0;
      r_err_q    <= 1'b0;
      w_err_q    <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
      r_hold     <= '0;
    end else begin
      r_valid_q <= accept_r;
      r_err_q   <= accept_r & ~r_aligned;
      w_err_q   <= accept_w & ~w_aligned;
      if (do_read) begin
        fwd_mask_q <= same_word ? strb_mask : '0;
        fwd_data_q <= bus.w_data;
      end
      if (r_valid_q) r_hold <= r_data_now;
    end
  end

  assign r_data_now = r_err_q ? '0 : ((arr_q & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q));

  assign bus.r_data  = r_valid_q ? r_data_now : r_hold;
  assign bus.r_valid = r_valid_q;
  assign bus.r_err   = r_err_q;
  assign bus.w_err   = w_err_q;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_byte_ram.sv
// tb/tb_byte_ram.sv - self-checking bench for byte_ram, 32-bit and 64-bit builds with MEM_NUM=16
module tb_byte_ram;

  logic clk;
  logic rstn;

  byte_ram_if #(.DW(32), .AW(32)) bus32 ();
  byte_ram_if #(.DW(64), .AW(32)) bus64 ();

  byte_ram #(.DW(32), .AW(32), .MEM_NUM(16)) dut32 (.clk(clk), .rstn(rstn), .bus(bus32));
  byte_ram #(.DW(64), .AW(32), .MEM_NUM(16)) dut64 (.clk(clk), .rstn(rstn), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [16];

`ifdef BYTE_RAM_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus32.wen = 0; bus32.ren = 0; bus32.w_addr = 0; bus32.r_addr = 0;
    bus32.w_data = 0; bus32.w_strb = 0;
    bus64.wen = 0; bus64.ren = 0; bus64.w_addr = 0; bus64.r_addr = 0;
    bus64.w_data = 0; bus64.w_strb = 0;
  endtask

  // Reference memory: aligned writes update strobed bytes of word (addr/4) mod 16
  function automatic void mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[1:0] == 2'b00)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[(a >> 2) % 16][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    return (a[1:0] != 2'b00) ? 32'h0 : model[(a >> 2) % 16];
  endfunction

  task automatic count_busy(output int n);
    n = 0;
    while (bus32.busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    idle();
    rstn = 0;
    step(); step();
    n_cmp++; if (bus32.r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid got %b want 0", bus32.r_valid); end
    n_cmp++; if (bus32.r_err !== 1'b0) begin n_fail++; $display("FAIL reset_r_err got %b want 0", bus32.r_err); end
    n_cmp++; if (bus32.w_err !== 1'b0) begin n_fail++; $display("FAIL reset_w_err got %b want 0", bus32.w_err); end
    n_cmp++; if (bus32.r_data !== 32'h0) begin n_fail++; $display("FAIL reset_r_data got %h want 0", bus32.r_data); end
    n_cmp++; if (bus32.busy !== CLEAR) begin n_fail++; $display("FAIL reset_busy got %b want %b", bus32.busy, CLEAR); end
  endtask

  task automatic test_init_sweep();
    int n;
    rstn = 1;
    count_busy(n);
    n_cmp++; if (n !== (CLEAR ? 16 : 0)) begin n_fail++; $display("FAIL sweep_busy_cycles got %0d want %0d", n, CLEAR ? 16 : 0); end
    while (bus64.busy === 1'b1 && n < 200) begin n++; step(); end
    if (!CLEAR) begin
      for (int i = 0; i < 16; i++) begin
        bus32.wen = 1; bus32.w_addr = 32'(i * 4); bus32.w_data = 0; bus32.w_strb = 4'hF;
        step();
      end
      idle();
    end
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic test_back_to_back();
    bus32.ren = 1; bus32.r_addr = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      bus32.r_addr = 32'((i + 1) * 4);
      if (i == 15) bus32.ren = 0;
      n_cmp++; if (bus32.r_valid !== 1'b1 || bus32.r_data !== 32'h0)
        begin n_fail++; $display("FAIL init_read[%0d] got v=%b d=%h want v=1 d=0", i, bus32.r_valid, bus32.r_data); end
    end
    step();
    n_cmp++; if (bus32.r_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra_valid got %b want 0", bus32.r_valid); end
  endtask

  task automatic test_strobe_merge();
    bus32.wen = 1; bus32.w_addr = 32'h10; bus32.w_data = 32'hDEADBEEF; bus32.w_strb = 4'b1111;
    mwrite(32'h10, 32'hDEADBEEF, 4'b1111);
    step();
    bus32.w_data = 32'h00001122; bus32.w_strb = 4'b0001;
    mwrite(32'h10, 32'h00001122, 4'b0001);
    step();
    n_cmp++; if (bus32.w_err !== 1'b0) begin n_fail++; $display("FAIL strobe_w_err got %b want 0", bus32.w_err); end
    bus32.wen = 0; bus32.ren = 1; bus32.r_addr = 32'h10;
    step();
    bus32.ren = 0;
    n_cmp++; if (bus32.r_data !== 32'hDEADBE22 || bus32.r_valid !== 1'b1)
      begin n_fail++; $display("FAIL strobe_read got v=%b d=%h want v=1 d=deadbe22", bus32.r_valid, bus32.r_data); end
    step();
    n_cmp++; if (bus32.r_valid !== 1'b0 || bus32.r_data !== 32'hDEADBE22)
      begin n_fail++; $display("FAIL strobe_hold got v=%b d=%h want v=0 d=deadbe22", bus32.r_valid, bus32.r_data); end
  endtask

  task automatic test_forward();
    bus32.wen = 1; bus32.w_addr = 32'h20; bus32.w_data = 32'h11223344; bus32.w_strb = 4'hF;
    mwrite(32'h20, 32'h11223344, 4'hF);
    step();
    bus32.w_data = 32'hAABBCCDD; bus32.w_strb = 4'b1100; bus32.ren = 1; bus32.r_addr = 32'h20;
    mwrite(32'h20, 32'hAABBCCDD, 4'b1100);
    step();
    idle();
    n_cmp++; if (bus32.r_data !== 32'hAABB3344 || bus32.r_valid !== 1'b1)
      begin n_fail++; $display("FAIL forward got v=%b d=%h want v=1 d=aabb3344", bus32.r_valid, bus32.r_data); end
    step();
  endtask

  task automatic test_misaligned();
    bus32.wen = 1; bus32.w_addr = 32'h12; bus32.w_data = 32'hFFFFFFFF; bus32.w_strb = 4'hF;
    step();
    bus32.wen = 0;
    n_cmp++; if (bus32.w_err !== 1'b1) begin n_fail++; $display("FAIL mis_w_err got %b want 1", bus32.w_err); end
    bus32.ren = 1; bus32.r_addr = 32'h10;
    step();
    n_cmp++; if (bus32.w_err !== 1'b0) begin n_fail++; $display("FAIL mis_w_err_pulse got %b want 0", bus32.w_err); end
    n_cmp++; if (bus32.r_data !== mread(32'h10)) begin n_fail++; $display("FAIL mis_unchanged got %h want %h", bus32.r_data, mread(32'h10)); end
    bus32.r_addr = 32'h13;
    step();
    bus32.ren = 0;
    n_cmp++; if (bus32.r_data !== 32'h0 || bus32.r_valid !== 1'b1 || bus32.r_err !== 1'b1)
      begin n_fail++; $display("FAIL mis_read got v=%b e=%b d=%h want v=1 e=1 d=0", bus32.r_valid, bus32.r_err, bus32.r_data); end
    step();
    n_cmp++; if (bus32.r_err !== 1'b0 || bus32.r_valid !== 1'b0 || bus32.r_data !== 32'h0)
      begin n_fail++; $display("FAIL mis_after got v=%b e=%b d=%h want v=0 e=0 d=0", bus32.r_valid, bus32.r_err, bus32.r_data); end
  endtask

  task automatic test_wrap();
    bus32.wen = 1; bus32.w_addr = 32'h40; bus32.w_data = 32'h55; bus32.w_strb = 4'hF;
    mwrite(32'h40, 32'h55, 4'hF);
    step();
    bus32.wen = 0; bus32.ren = 1; bus32.r_addr = 32'h0;
    step();
    bus32.ren = 0;
    n_cmp++; if (bus32.r_data !== 32'h00000055) begin n_fail++; $display("FAIL wrap got %h want 00000055", bus32.r_data); end
  endtask

  task automatic test_random();
    logic [31:0] hold;
    logic [31:0] wa, ra;
    logic        we, re;
    bus32.ren = 1; bus32.r_addr = 0;
    hold = mread(0);
    step();
    bus32.ren = 0;
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 32'($urandom_range(0, 127));
      ra = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) wa[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) ra = wa;
      bus32.wen = we; bus32.w_addr = wa; bus32.w_data = $urandom; bus32.w_strb = 4'($urandom_range(0, 15));
      bus32.ren = re; bus32.r_addr = ra;
      if (we) mwrite(wa, bus32.w_data, bus32.w_strb);
      if (re) hold = mread(ra);
      step();
      n_cmp++; if (bus32.r_valid !== re || bus32.r_err !== (re && ra[1:0] != 0) || bus32.w_err !== (we && wa[1:0] != 0))
        begin n_fail++; $display("FAIL rand_flags[%0d] got v=%b re=%b we=%b", i, bus32.r_valid, bus32.r_err, bus32.w_err); end
      n_cmp++; if (bus32.r_data !== hold)
        begin n_fail++; $display("FAIL rand_data[%0d] got %h want %h", i, bus32.r_data, hold); end
    end
    idle();
    step();
  endtask

  task automatic test_wide();
    logic [63:0] exp;
    exp = (64'hDEADBEEF_CAFEF00D & ~64'hFF) | 64'h22;
    bus64.wen = 1; bus64.w_addr = 32'h10; bus64.w_data = 64'hDEADBEEF_CAFEF00D; bus64.w_strb = 8'hFF;
    step();
    bus64.w_data = 64'h00000000_00001122; bus64.w_strb = 8'h01;
    step();
    bus64.wen = 0; bus64.ren = 1; bus64.r_addr = 32'h10;
    step();
    bus64.ren = 0;
    n_cmp++; if (bus64.r_data !== exp || bus64.r_valid !== 1'b1)
      begin n_fail++; $display("FAIL wide_read got v=%b d=%h want v=1 d=%h", bus64.r_valid, bus64.r_data, exp); end
    bus64.wen = 1; bus64.w_addr = 32'h14; bus64.w_data = '1; bus64.w_strb = 8'hFF;
    step();
    bus64.wen = 0;
    n_cmp++; if (bus64.w_err !== 1'b1) begin n_fail++; $display("FAIL wide_w_err got %b want 1", bus64.w_err); end
    bus64.ren = 1;
    step();
    bus64.ren = 0;
    n_cmp++; if (bus64.r_data !== exp) begin n_fail++; $display("FAIL wide_unchanged got %h want %h", bus64.r_data, exp); end
    step();
  endtask

  task automatic test_reset_in_flight();
    int n;
    bus32.ren = 1; bus32.r_addr = 32'h10;
    step();
    bus32.ren = 0;
    rstn = 0;
    #1;
    n_cmp++; if (bus32.r_valid !== 1'b0 || bus32.r_data !== 32'h0)
      begin n_fail++; $display("FAIL flight_reset got v=%b d=%h want v=0 d=0", bus32.r_valid, bus32.r_data); end
    step();
    rstn = 1;
    n_cmp++; if (bus32.r_valid !== 1'b0) begin n_fail++; $display("FAIL flight_late_valid got %b want 0", bus32.r_valid); end
    count_busy(n);
    n_cmp++; if (n !== (CLEAR ? 16 : 0)) begin n_fail++; $display("FAIL flight_busy got %0d want %0d", n, CLEAR ? 16 : 0); end
    if (CLEAR) for (int i = 0; i < 16; i++) model[i] = 32'h0;
    bus32.ren = 1; bus32.r_addr = 32'h20;
    step();
    bus32.ren = 0;
    n_cmp++; if (bus32.r_data !== mread(32'h20)) begin n_fail++; $display("FAIL flight_contents got %h want %h", bus32.r_data, mread(32'h20)); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rstn = 0;
    step();
    rstn = 1;
    for (int i = 0; i < 3; i++) step();
    bus32.wen = 1; bus32.w_addr = 32'h4; bus32.w_data = 32'h12345678; bus32.w_strb = 4'hF;
    bus32.ren = 1; bus32.r_addr = 32'h4;
    step();
    idle();
    n_cmp++; if (bus32.r_valid !== 1'b0 || bus32.w_err !== 1'b0)
      begin n_fail++; $display("FAIL busy_drop got v=%b we=%b want 0 0", bus32.r_valid, bus32.w_err); end
    for (int i = 0; i < 3; i++) step();
    rstn = 0;
    #1;
    step();
    rstn = 1;
    count_busy(n);
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL mid_sweep_busy got %0d want 16", n); end
    bus32.ren = 1; bus32.r_addr = 32'h4;
    step();
    bus32.ren = 0;
    n_cmp++; if (bus32.r_data !== 32'h0 || bus32.r_valid !== 1'b1)
      begin n_fail++; $display("FAIL mid_sweep_read got v=%b d=%h want v=1 d=0", bus32.r_valid, bus32.r_data); end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_back_to_back();
    test_strobe_merge();
    test_forward();
    test_misaligned();
    test_wrap();
    test_random();
    test_wide();
    test_reset_in_flight();
    if (CLEAR) test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
